key_led_ctrl: RTL and testbench



---
 rtl/key_led_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_key_led_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/key_led_ctrl.sv
// Four-key / four-LED controller: synchronises and debounces active-low keys,
// turns accepted presses into mode/pause/clear events and drives timed LED patterns.
module key_led_ctrl #(
    parameter int DB_CNT   = 1000000,
    parameter int STEP_CNT = 12500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key,
    output logic [3:0] led,
    output logic [1:0] mode,
    output logic       paused,
    output logic [3:0] key_evt
);

    localparam int DB_W   = $clog2(DB_CNT);
    localparam int STEP_W = $clog2(STEP_CNT);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CNT - 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_CNT - 1);

    typedef enum logic [1:0] {
        MODE_BAR   = 2'd0,
        MODE_RUN   = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_ECHO  = 2'd3
    } mode_e;

    // ------------------------------------------------------------------
    // Synchroniser and debounce
    // ------------------------------------------------------------------
    logic [3:0]      sync1_q, sync2_q;
    logic [3:0]      stable_q, stable_d;
    logic [3:0]      stable_dly_q;
    logic [DB_W-1:0] db_cnt_q [4];
    logic [DB_W-1:0] db_cnt_d [4];
    logic [3:0]      key_evt_q, key_evt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 4'b1111;
            sync2_q <= 4'b1111;
        end else begin
            sync1_q <= key;
            sync2_q <= sync1_q;
        end
    end

    // Any sample matching the accepted level restarts the count, so bounce
    // never accumulates towards acceptance.
    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < 4; i++) begin
            db_cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    stable_d[i] = sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
                end
            end
        end
    end

    // Press = accepted 1->0 transition; detected one cycle after acceptance.
    assign key_evt_d = stable_dly_q & ~stable_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stable_q     <= 4'b1111;
            stable_dly_q <= 4'b1111;
            db_cnt_q     <= '{default: '0};
            key_evt_q    <= 4'b0000;
        end else begin
            stable_q     <= stable_d;
            stable_dly_q <= stable_q;
            db_cnt_q     <= db_cnt_d;
            key_evt_q    <= key_evt_d;
        end
    end

    // ------------------------------------------------------------------
    // Mode / pause state machine
    // ------------------------------------------------------------------
    mode_e mode_q, mode_d;
    logic  paused_q, paused_d;
    logic  clear;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q   <= MODE_BAR;
            paused_q <= 1'b0;
        end else begin
            mode_q   <= mode_d;
            paused_q <= paused_d;
        end
    end

    always_comb begin
        mode_d   = mode_q;
        paused_d = paused_q ^ key_evt_q[2];
        case (key_evt_q[1:0])
            2'b01:   mode_d = mode_e'(mode_q + 2'd1);
            2'b10:   mode_d = mode_e'(mode_q - 2'd1);
            default: mode_d = mode_q;
        endcase
        clear = key_evt_q[3] || (mode_d != mode_q);
    end

    // ------------------------------------------------------------------
    // Step tick and pattern state
    // ------------------------------------------------------------------
    logic [STEP_W-1:0] tick_cnt_q, tick_cnt_d;
    logic              tick;
    logic [2:0]        level_q, level_d;
    logic [1:0]        pos_q, pos_d;
    logic              blink_q, blink_d;

    assign tick = !paused_q && (tick_cnt_q == STEP_LAST);

    // A clear in the same cycle as a tick discards the tick.
    always_comb begin
        tick_cnt_d = tick_cnt_q;
        level_d    = level_q;
        pos_d      = pos_q;
        blink_d    = blink_q;
        if (clear) begin
            tick_cnt_d = '0;
            level_d    = 3'd0;
            pos_d      = 2'd0;
            blink_d    = 1'b0;
        end else if (!paused_q) begin
            tick_cnt_d = tick ? '0 : tick_cnt_q + STEP_W'(1);
            if (tick) begin
                case (mode_q)
                    MODE_BAR:   level_d = (level_q == 3'd4) ? 3'd0 : level_q + 3'd1;
                    MODE_RUN:   pos_d   = pos_q + 2'd1;
                    MODE_BLINK: blink_d = ~blink_q;
                    default:    level_d = level_q;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt_q <= '0;
            level_q    <= 3'd0;
            pos_q      <= 2'd0;
            blink_q    <= 1'b0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            level_q    <= level_d;
            pos_q      <= pos_d;
            blink_q    <= blink_d;
        end
    end

    // ------------------------------------------------------------------
    // LED map (active-low, registered)
    // ------------------------------------------------------------------
    logic [3:0] led_q, led_d;

    always_comb begin
        led_d = 4'b1111;
        case (mode_q)
            MODE_BAR: begin
                case (level_q)
                    3'd0:    led_d = 4'b1111;
                    3'd1:    led_d = 4'b1110;
                    3'd2:    led_d = 4'b1100;
                    3'd3:    led_d = 4'b1000;
                    default: led_d = 4'b0000;
                endcase
            end
            MODE_RUN:   led_d = ~(4'b0001 << pos_q);
            MODE_BLINK: led_d = blink_q ? 4'b0000 : 4'b1111;
            default:    led_d = stable_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_q <= 4'b1111;
        end else begin
            led_q <= led_d;
        end
    end

    assign led     = led_q;
    assign mode    = mode_q;
    assign paused  = paused_q;
    assign key_evt = key_evt_q;

endmodule

// File: tb/tb_key_led_ctrl.sv
// Directed, table-driven bench for key_led_ctrl with DB_CNT=4, STEP_CNT=8.
// Each record: optional reset, key value to apply, cycles to advance, expected outputs.
module tb_key_led_ctrl;

    localparam int DB   = 4;
    localparam int STEP = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] key = 4'hF;
    logic [3:0] led;
    logic [1:0] mode;
    logic       paused;
    logic [3:0] key_evt;

    int n_checks = 0;
    int n_fail   = 0;
    int evt_total;

    always #5 clk = ~clk;

    key_led_ctrl #(.DB_CNT(DB), .STEP_CNT(STEP)) dut (
        .clk     (clk),
        .rst     (rst),
        .key     (key),
        .led     (led),
        .mode    (mode),
        .paused  (paused),
        .key_evt (key_evt)
    );

    // Running count of event pulse bits since the last reset.
    always @(negedge clk) begin
        if (rst) evt_total <= 0;
        else     evt_total <= evt_total + $countones(key_evt);
    end

    typedef struct {
        bit         rst_b;
        logic [3:0] key;
        int         wait_n;
        logic [3:0] led;
        logic [1:0] mode;
        logic       paused;
        logic [3:0] evt;
        int         total;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit r, input logic [3:0] k, input int w, input logic [3:0] l,
                       input logic [1:0] m, input logic p, input logic [3:0] e, input int t);
        vec_t v;
        v.rst_b = r; v.key = k; v.wait_n = w; v.led = l;
        v.mode = m; v.paused = p; v.evt = e; v.total = t;
        vecs.push_back(v);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        key = 4'hF;
        step(2);
        rst = 1'b0;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    int first_pulse;
    int n_pulse;

    initial begin
        // 1: reset then free-running bar graph (edge numbers in comments)
        add(1, 4'hF, 0, 4'hF, 2'd0, 0, 4'h0, 0);   // reset state
        add(0, 4'hF, 8, 4'hF, 2'd0, 0, 4'h0, 0);   // E8
        add(0, 4'hF, 1, 4'hE, 2'd0, 0, 4'h0, 0);   // E9
        add(0, 4'hF, 8, 4'hC, 2'd0, 0, 4'h0, 0);   // E17
        add(0, 4'hF, 8, 4'h8, 2'd0, 0, 4'h0, 0);   // E25
        add(0, 4'hF, 8, 4'h0, 2'd0, 0, 4'h0, 0);   // E33
        add(0, 4'hF, 8, 4'hF, 2'd0, 0, 4'h0, 0);   // E41
        // 2: bouncing key[0], settles before E46
        add(0, 4'hE, 1, 4'hF, 2'd0, 0, 4'h0, 0);   // E42
        add(0, 4'hF, 1, 4'hF, 2'd0, 0, 4'h0, 0);   // E43
        add(0, 4'hE, 1, 4'hF, 2'd0, 0, 4'h0, 0);   // E44
        add(0, 4'hF, 1, 4'hF, 2'd0, 0, 4'h0, 0);   // E45
        add(0, 4'hE, 6, 4'hE, 2'd0, 0, 4'h0, 0);   // E51
        add(0, 4'hE, 1, 4'hE, 2'd0, 0, 4'h1, 0);   // E52 pulse
        add(0, 4'hE, 1, 4'hE, 2'd1, 0, 4'h0, 1);   // E53 mode RUN
        add(0, 4'hE, 1, 4'hE, 2'd1, 0, 4'h0, 1);   // E54
        add(0, 4'hE, 7, 4'hE, 2'd1, 0, 4'h0, 1);   // E61
        add(0, 4'hE, 1, 4'hD, 2'd1, 0, 4'h0, 1);   // E62
        // 3: pause / resume in RUN
        add(0, 4'hA, 6, 4'hD, 2'd1, 0, 4'h0, 1);   // E68
        add(0, 4'hA, 1, 4'hD, 2'd1, 0, 4'h4, 1);   // E69
        add(0, 4'hA, 1, 4'hB, 2'd1, 1, 4'h0, 2);   // E70 paused
        add(0, 4'hA, 50, 4'hB, 2'd1, 1, 4'h0, 2);  // E120 frozen
        add(0, 4'hE, 7, 4'hB, 2'd1, 1, 4'h0, 2);   // E127 release
        add(0, 4'hA, 6, 4'hB, 2'd1, 1, 4'h0, 2);   // E133
        add(0, 4'hA, 1, 4'hB, 2'd1, 1, 4'h4, 2);   // E134
        add(0, 4'hA, 1, 4'hB, 2'd1, 0, 4'h0, 3);   // E135 resumed
        add(0, 4'hA, 7, 4'hB, 2'd1, 0, 4'h0, 3);   // E142
        add(0, 4'hA, 1, 4'h7, 2'd1, 0, 4'h0, 3);   // E143
        // 4: down-wrap to ECHO, echo of stable keys, pause on press only
        add(1, 4'hD, 7, 4'hF, 2'd0, 0, 4'h2, 0);   // E7
        add(0, 4'hD, 1, 4'hF, 2'd3, 0, 4'h0, 1);   // E8
        add(0, 4'h9, 1, 4'hD, 2'd3, 0, 4'h0, 1);   // E9
        add(0, 4'h9, 5, 4'hD, 2'd3, 0, 4'h0, 1);   // E14
        add(0, 4'h9, 1, 4'h9, 2'd3, 0, 4'h4, 1);   // E15
        add(0, 4'h9, 1, 4'h9, 2'd3, 1, 4'h0, 2);   // E16
        add(0, 4'hD, 1, 4'h9, 2'd3, 1, 4'h0, 2);   // E17 release key[2]
        add(0, 4'hD, 5, 4'h9, 2'd3, 1, 4'h0, 2);   // E22
        add(0, 4'hD, 1, 4'hD, 2'd3, 1, 4'h0, 2);   // E23
        add(0, 4'hD, 10, 4'hD, 2'd3, 1, 4'h0, 2);  // E33
        // 5: simultaneous up/down, clear coinciding with a tick at level 3
        add(1, 4'hC, 7, 4'hF, 2'd0, 0, 4'h3, 0);   // E7
        add(0, 4'hC, 1, 4'hF, 2'd0, 0, 4'h0, 2);   // E8
        add(0, 4'hC, 16, 4'hC, 2'd0, 0, 4'h0, 2);  // E24
        add(0, 4'h4, 1, 4'h8, 2'd0, 0, 4'h0, 2);   // E25
        add(0, 4'h4, 6, 4'h8, 2'd0, 0, 4'h8, 2);   // E31
        add(0, 4'h4, 1, 4'h8, 2'd0, 0, 4'h0, 3);   // E32 clear + tick
        add(0, 4'h4, 1, 4'hF, 2'd0, 0, 4'h0, 3);   // E33
        add(0, 4'h4, 7, 4'hF, 2'd0, 0, 4'h0, 3);   // E40
        add(0, 4'h4, 1, 4'hE, 2'd0, 0, 4'h0, 3);   // E41
        // 6: reach BLINK, then reset mid-bounce (hand sequence below)
        add(1, 4'hE, 7, 4'hF, 2'd0, 0, 4'h1, 0);   // E7
        add(0, 4'hE, 1, 4'hF, 2'd1, 0, 4'h0, 1);   // E8
        add(0, 4'hF, 6, 4'hE, 2'd1, 0, 4'h0, 1);   // E14
        add(0, 4'hE, 7, 4'hD, 2'd1, 0, 4'h1, 1);   // E21
        add(0, 4'hE, 1, 4'hD, 2'd2, 0, 4'h0, 2);   // E22
        add(0, 4'hE, 1, 4'hF, 2'd2, 0, 4'h0, 2);   // E23
        add(0, 4'hE, 7, 4'hF, 2'd2, 0, 4'h0, 2);   // E30
        add(0, 4'hE, 1, 4'h0, 2'd2, 0, 4'h0, 2);   // E31

        @(posedge clk);
        #1;
        foreach (vecs[i]) begin
            if (vecs[i].rst_b) do_reset();
            key = vecs[i].key;
            step(vecs[i].wait_n);
            check($sformatf("v%0d led", i),    32'(led),       32'(vecs[i].led));
            check($sformatf("v%0d mode", i),   32'(mode),      32'(vecs[i].mode));
            check($sformatf("v%0d paused", i), 32'(paused),    32'(vecs[i].paused));
            check($sformatf("v%0d key_evt", i), 32'(key_evt),  32'(vecs[i].evt));
            check($sformatf("v%0d evt_total", i), 32'(evt_total), 32'(vecs[i].total));
        end

        // Asynchronous reset while key[0] bounces and BLINK shows all-lit.
        key = 4'hF;
        step(1);
        key = 4'hE;
        #2;
        rst = 1'b1;
        #1;
        check("async_rst led", 32'(led), 32'hF);
        check("async_rst mode", 32'(mode), 32'd0);
        check("async_rst paused", 32'(paused), 32'd0);
        check("async_rst key_evt", 32'(key_evt), 32'h0);
        step(2);
        rst = 1'b0;

        // key[0] held low across reset release: one pulse after normal latency.
        first_pulse = 0;
        n_pulse     = 0;
        for (int c = 1; c <= 20; c++) begin
            step(1);
            if (key_evt[0]) begin
                n_pulse++;
                if (first_pulse == 0) first_pulse = c;
            end
        end
        check("held_rst pulse_count", 32'(n_pulse), 32'd1);
        check("held_rst pulse_cycle", 32'(first_pulse), 32'd7);
        check("held_rst mode", 32'(mode), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
